// File: rtl/hc04_selftest.sv
// Built-in self-test sequencer for a 74HC04 hex inverter: walks 14 patterns onto A, checks Y == ~A.
// Optional macro HC04_SELFTEST_ABORT_EN ends the run at the first failing pattern.
module hc04_selftest #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [6:1] Y,
    output logic [6:1] A,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [6:1] FAIL_MASK,
    output logic [3:0] FAIL_PAT
);

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK} state_e;

    localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES);
    localparam logic [3:0] LAST_IDX    = 4'd13;
    localparam logic [3:0] NO_FAIL     = 4'hF;

    state_e     state_q, state_d;
    logic [6:1] a_q, a_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [6:1] fail_mask_q, fail_mask_d;
    logic [3:0] fail_pat_q, fail_pat_d;
    logic [3:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;

    logic [6:1] mismatch;
    logic       abort_hit;

    function automatic logic [6:1] pattern(input logic [3:0] i);
        logic [6:1] p;
        p = '0;
        if (i == 4'd1)
            p = '1;
        else if (i >= 4'd2 && i <= 4'd7)
            p = 6'b000001 << (i - 4'd2);
        else if (i >= 4'd8 && i <= 4'd13)
            p = ~(6'b000001 << (i - 4'd8));
        return p;
    endfunction

    // Y is only sampled in CHECK, after A has been held for the full settle time.
    assign mismatch = Y ^ ~a_q;

`ifdef HC04_SELFTEST_ABORT_EN
    assign abort_hit = |mismatch;
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case leaves a latch.
        state_d     = state_q;
        a_d         = a_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_mask_d = fail_mask_q;
        fail_pat_d  = fail_pat_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                if (START) begin
                    a_d         = pattern(4'd0);
                    idx_d       = 4'd0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    fail_mask_d = '0;
                    fail_pat_d  = NO_FAIL;
                    cnt_d       = SETTLE_INIT;
                    state_d     = SETTLE;
                end
            end

            SETTLE: begin
                if (cnt_q == 8'd1)
                    state_d = CHECK;
                else
                    cnt_d = cnt_q - 8'd1;
            end

            CHECK: begin
                if (abort_hit) begin
                    fail_mask_d = mismatch;
                    fail_pat_d  = idx_q;
                    pass_d      = 1'b0;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    a_d         = '0;
                    state_d     = IDLE;
                end else begin
                    fail_mask_d = fail_mask_q | mismatch;
                    if (mismatch != '0 && fail_pat_q == NO_FAIL)
                        fail_pat_d = idx_q;
                    if (idx_q == LAST_IDX) begin
                        pass_d  = (fail_mask_d == '0);
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        a_d     = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        a_d     = pattern(idx_q + 4'd1);
                        cnt_d   = SETTLE_INIT;
                        state_d = SETTLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            a_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_mask_q <= '0;
            fail_pat_q  <= NO_FAIL;
            idx_q       <= 4'd0;
            cnt_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_mask_q <= fail_mask_d;
            fail_pat_q  <= fail_pat_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
        end
    end

    assign A         = a_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign PASS      = pass_q;
    assign FAIL_MASK = fail_mask_q;
    assign FAIL_PAT  = fail_pat_q;

endmodule
